// File: rtl/axi4_beat_addr_gen.sv
// Expands AXI4 AW/AR address commands into a per-beat stream (address, ID, index, LAST)
// covering FIXED, INCR and WRAP arithmetic; a reserved burst or illegal WRAP length runs as INCR.
module axi4_beat_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [7:0]            CMD_LEN,
    input  logic [2:0]            CMD_SIZE,
    input  logic [1:0]            CMD_BURST,
    input  logic [ID_WIDTH-1:0]   CMD_ID,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    output logic [ADDR_WIDTH-1:0] BEAT_ADDR,
    output logic [ID_WIDTH-1:0]   BEAT_ID,
    output logic [7:0]            BEAT_IDX,
    output logic                  BEAT_LAST,
    output logic                  BEAT_VALID,
    input  logic                  BEAT_READY,
    output logic                  CMD_ERR
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        MODE_FIXED = 2'b00,
        MODE_INCR  = 2'b01,
        MODE_WRAP  = 2'b10
    } mode_e;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    mode_e                 mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] lower_q, lower_d;
    logic [ADDR_WIDTH-1:0] upper_q, upper_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [7:0]            idx_q, idx_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic                  last_q, last_d;
    logic                  err_q, err_d;

    logic                  cmd_ready_s;
    logic                  accept_s;
    logic                  wrap_len_ok_s;
    logic                  cmd_bad_s;
    mode_e                 cmd_mode_s;
    logic [ADDR_WIDTH-1:0] cmd_wrap_bytes_s;
    logic [ADDR_WIDTH-1:0] cmd_lower_s;
    logic [ADDR_WIDTH-1:0] beat_incr_s;
    logic [ADDR_WIDTH-1:0] aligned_s;
    logic [ADDR_WIDTH-1:0] next_lin_s;
    logic [ADDR_WIDTH-1:0] next_addr_s;

    // Command decode: effective burst mode, error flag and wrap window of the offered command.
    always_comb begin
        wrap_len_ok_s    = (CMD_LEN == 8'd1) || (CMD_LEN == 8'd3) ||
                           (CMD_LEN == 8'd7) || (CMD_LEN == 8'd15);
        cmd_bad_s        = 1'b0;
        cmd_mode_s       = MODE_INCR;
        case (CMD_BURST)
            2'b00: cmd_mode_s = MODE_FIXED;
            2'b01: cmd_mode_s = MODE_INCR;
            2'b10: begin
                if (wrap_len_ok_s) begin
                    cmd_mode_s = MODE_WRAP;
                end else begin
                    cmd_mode_s = MODE_INCR;
                    cmd_bad_s  = 1'b1;
                end
            end
            default: begin
                cmd_mode_s = MODE_INCR;
                cmd_bad_s  = 1'b1;
            end
        endcase
        cmd_wrap_bytes_s = (ADDR_WIDTH'(CMD_LEN) + ADDR_ONE) << CMD_SIZE;
        cmd_lower_s      = CMD_ADDR & ~(cmd_wrap_bytes_s - ADDR_ONE);
    end

    // Next beat address from the current beat: align, step, and fold back inside the wrap window.
    always_comb begin
        beat_incr_s = ADDR_ONE << size_q;
        aligned_s   = addr_q & ~(beat_incr_s - ADDR_ONE);
        next_lin_s  = aligned_s + beat_incr_s;
        case (mode_q)
            MODE_FIXED: next_addr_s = addr_q;
            MODE_WRAP:  next_addr_s = (next_lin_s == upper_q) ? lower_q : next_lin_s;
            default:    next_addr_s = next_lin_s;
        endcase
    end

    // Handshake: ready while idle, or on the final beat as it drains so commands chain without a bubble.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cmd_ready_s = 1'b1;
        end else begin
            cmd_ready_s = BEAT_READY & last_q;
        end
        accept_s = CMD_VALID & cmd_ready_s;
    end

    // FSM next state and beat register updates.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        lower_d = lower_q;
        upper_d = upper_q;
        id_d    = id_q;
        idx_d   = idx_q;
        len_d   = len_q;
        size_d  = size_q;
        last_d  = last_q;
        err_d   = 1'b0;
        if (accept_s) begin
            state_d = ST_BUSY;
            mode_d  = cmd_mode_s;
            addr_d  = CMD_ADDR;
            lower_d = cmd_lower_s;
            upper_d = cmd_lower_s + cmd_wrap_bytes_s;
            id_d    = CMD_ID;
            idx_d   = 8'd0;
            len_d   = CMD_LEN;
            size_d  = CMD_SIZE;
            last_d  = (CMD_LEN == 8'd0);
            err_d   = cmd_bad_s;
        end else if ((state_q == ST_BUSY) && BEAT_READY) begin
            if (!last_q) begin
                addr_d = next_addr_s;
                idx_d  = idx_q + 8'd1;
                last_d = ((idx_q + 8'd1) == len_q);
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_INCR;
            addr_q  <= {ADDR_WIDTH{1'b0}};
            lower_q <= {ADDR_WIDTH{1'b0}};
            upper_q <= {ADDR_WIDTH{1'b0}};
            id_q    <= {ID_WIDTH{1'b0}};
            idx_q   <= 8'd0;
            len_q   <= 8'd0;
            size_q  <= 3'd0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            lower_q <= lower_d;
            upper_q <= upper_d;
            id_q    <= id_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            size_q  <= size_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign CMD_READY  = cmd_ready_s;
    assign BEAT_VALID = (state_q == ST_BUSY);
    assign BEAT_ADDR  = addr_q;
    assign BEAT_ID    = id_q;
    assign BEAT_IDX   = idx_q;
    assign BEAT_LAST  = last_q;
    assign CMD_ERR    = err_q;

endmodule
